// File: rtl/code_lock_ctrl_pkg.sv
// Shared state encoding and geometry helpers for the code-lock controller.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED    = 3'd0,
    ST_CHECK     = 3'd1,
    ST_OPEN      = 3'd2,
    ST_NEW_ENTRY = 3'd3,
    ST_ALARM     = 3'd4
  } lock_state_e;

  function automatic int code_w(input int digits, input int dw);
    return digits * dw;
  endfunction

  localparam int CODE_W = code_w(4, 4);

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad-side and LED-side signals of the code-lock controller.
interface code_lock_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
);
  logic [DW-1:0]     data;
  logic              key_en;
  logic              set_mode;
  logic              lock;
  logic              alarm;
  logic              blink_en;
  logic [DIGITS-1:0] progress;
  logic [3:0]        tries_left;

  modport master (
    output data, key_en, set_mode,
    input  lock, alarm, blink_en, progress, tries_left
  );

  modport slave (
    input  data, key_en, set_mode,
    output lock, alarm, blink_en, progress, tries_left
  );
endinterface

// File: rtl/code_lock_ctrl_lock_timer.sv
// Loadable down-counter that parks at zero; done flags the zero count.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         ce,
  output logic         done
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (ce && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done = (count_q == '0);
endmodule

// File: rtl/code_lock_ctrl.sv
// Code-lock controller: digit capture, code check, attempt limit with alarm
// lockout, auto-relock and code change while open.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                      DIGITS       = 4,
  parameter int                      DW           = 4,
  parameter int                      MAX_TRIES    = 3,
  parameter int                      UNLOCK_CYC   = 500000000,
  parameter int                      ALARM_CYC    = 1000000000,
  parameter logic [DIGITS*DW-1:0]    DEFAULT_CODE = 16'h1234
) (
  input  logic            clk,
  input  logic            clr_n,
  code_lock_ctrl_if.slave bus
);
  localparam int CW   = code_w(DIGITS, DW);
  localparam int TMAX = (UNLOCK_CYC > ALARM_CYC) ? UNLOCK_CYC : ALARM_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int NW   = $clog2(DIGITS + 1);

  localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] T_ALARM   = TW'(ALARM_CYC - 1);
  localparam logic [NW-1:0] LAST_DIG  = NW'(DIGITS - 1);
  localparam logic [3:0]    TRIES_MAX = 4'(MAX_TRIES);

  lock_state_e   state_q, state_d;
  logic [CW-1:0] entry_q, entry_d;
  logic [CW-1:0] code_q,  code_d;
  logic [NW-1:0] cnt_q,   cnt_d;
  logic [3:0]    fails_q, fails_d;
  logic [CW-1:0] captured;
  logic          t_load, t_ce, t_done;
  logic [TW-1:0] t_val;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_LOCKED;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      fails_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fails_q <= fails_d;
    end
  end

  // First digit entered ends up in the most significant position.
  assign captured = (entry_q << DW) | CW'(bus.data);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    fails_d = fails_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_ce    = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (bus.key_en) begin
          entry_d = captured;
          cnt_d   = cnt_q + NW'(1);
          if (cnt_q == LAST_DIG) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q == code_q) begin
          state_d = ST_OPEN;
          fails_d = '0;
          t_load  = 1'b1;
          t_val   = T_UNLOCK;
        end else begin
          fails_d = fails_q + 4'd1;
          if ((fails_q + 4'd1) == TRIES_MAX) begin
            state_d = ST_ALARM;
            t_load  = 1'b1;
            t_val   = T_ALARM;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        t_ce = 1'b1;
        // A key press outranks a relock timeout landing in the same cycle.
        if (bus.key_en) begin
          if (bus.set_mode) begin
            state_d = ST_NEW_ENTRY;
            entry_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (t_done) begin
          state_d = ST_LOCKED;
        end
      end
      ST_NEW_ENTRY: begin
        if (bus.key_en) begin
          entry_d = captured;
          cnt_d   = cnt_q + NW'(1);
          if (cnt_q == LAST_DIG) begin
            code_d  = captured;
            entry_d = '0;
            cnt_d   = '0;
            state_d = ST_OPEN;
            t_load  = 1'b1;
            t_val   = T_UNLOCK;
          end
        end
      end
      ST_ALARM: begin
        t_ce = 1'b1;
        if (t_done) begin
          state_d = ST_LOCKED;
          fails_d = '0;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (t_load),
    .load_val (t_val),
    .ce       (t_ce),
    .done     (t_done)
  );

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      bus.progress[i] = (cnt_q > NW'(i));
    end
  end

  assign bus.lock       = !((state_q == ST_OPEN) || (state_q == ST_NEW_ENTRY));
  assign bus.alarm      = (state_q == ST_ALARM);
  assign bus.blink_en   = (state_q == ST_ALARM);
  assign bus.tries_left = TRIES_MAX - fails_q;
endmodule
